// File: rtl/piso_feeder.sv
// Parallel-in serial-out feeder: accepts one WIDTH-bit word at a time and
// presents it bit by bit to a downstream shift register, DIV cycles per bit.
module piso_feeder #(
   parameter int WIDTH = 4,
   parameter int DIV   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             lsb_first,
   output logic             din_ready,
   output logic             serial_in,
   output logic             shift,
   output logic             busy,
   output logic             done
);

   localparam int DW = $clog2(DIV + 1);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic FIRST_SHIFT = (DIV == 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             lsb_q, lsb_d;
   logic [BW-1:0]    bitCnt_q, bitCnt_d;
   logic [DW-1:0]    divCnt_q, divCnt_d;
   logic             serial_q, serial_d;
   logic             shift_q, shift_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         data_q   <= '0;
         lsb_q    <= 1'b0;
         bitCnt_q <= '0;
         divCnt_q <= '0;
         serial_q <= 1'b0;
         shift_q  <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         lsb_q    <= lsb_d;
         bitCnt_q <= bitCnt_d;
         divCnt_q <= divCnt_d;
         serial_q <= serial_d;
         shift_q  <= shift_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   // Outputs are registered, so the shift strobe is computed one cycle ahead
   // from the divider value the next cycle will hold.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      lsb_d    = lsb_q;
      bitCnt_d = bitCnt_q;
      divCnt_d = divCnt_q;
      serial_d = serial_q;
      shift_d  = 1'b0;
      busy_d   = busy_q;
      ready_d  = ready_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            serial_d = 1'b0;
            if (din_valid && ready_q) begin
               state_d  = SHIFT;
               data_d   = din;
               lsb_d    = lsb_first;
               bitCnt_d = '0;
               divCnt_d = '0;
               serial_d = lsb_first ? din[0] : din[WIDTH-1];
               shift_d  = FIRST_SHIFT;
               busy_d   = 1'b1;
               ready_d  = 1'b0;
            end
         end
         SHIFT: begin
            if (divCnt_q == DIV_LAST) begin
               if (bitCnt_q == BIT_LAST) begin
                  state_d  = IDLE;
                  bitCnt_d = '0;
                  divCnt_d = '0;
                  serial_d = 1'b0;
                  busy_d   = 1'b0;
                  ready_d  = 1'b1;
                  done_d   = 1'b1;
               end else begin
                  // The word register shifts toward the output end so the next
                  // bit always sits next to the one just sent.
                  bitCnt_d = bitCnt_q + BIT_ONE;
                  divCnt_d = '0;
                  data_d   = lsb_q ? (data_q >> 1) : (data_q << 1);
                  serial_d = lsb_q ? data_q[1] : data_q[WIDTH-2];
                  shift_d  = FIRST_SHIFT;
               end
            end else begin
               divCnt_d = divCnt_q + DIV_ONE;
               shift_d  = ((divCnt_q + DIV_ONE) == DIV_LAST);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign din_ready = ready_q;
   assign serial_in = serial_q;
   assign shift     = shift_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_piso_feeder.sv
// Directed bench for piso_feeder: per-cycle vector table on a DIV=2 instance,
// plus hand-written sequences for downstream capture and DIV=1 back-to-back.
module tb_piso_feeder;

   logic       clk = 1'b0;
   logic       rstN;
   logic [3:0] din;
   logic       vld;
   logic       lsb;

   logic rdy, ser, sh, bsy, dn;
   logic rdy1, ser1, sh1, bsy1, dn1;

   int vecCount  = 0;
   int missCount = 0;

   piso_feeder #(.WIDTH(4), .DIV(2)) dut (
      .clk(clk), .reset(rstN), .din(din), .din_valid(vld), .lsb_first(lsb),
      .din_ready(rdy), .serial_in(ser), .shift(sh), .busy(bsy), .done(dn)
   );

   piso_feeder #(.WIDTH(4), .DIV(1)) dut1 (
      .clk(clk), .reset(rstN), .din(din), .din_valid(vld), .lsb_first(lsb),
      .din_ready(rdy1), .serial_in(ser1), .shift(sh1), .busy(bsy1), .done(dn1)
   );

   always #5 clk = ~clk;

   // Downstream 4-bit siso stage and shift-pulse counter for the DIV=2 instance
   logic [3:0] siso = 4'b0000;
   int shiftCnt = 0;
   always @(posedge clk) begin
      if (sh) begin
         siso     <= {siso[2:0], ser};
         shiftCnt <= shiftCnt + 1;
      end
   end

   typedef struct {
      logic       r;
      logic       v;
      logic       l;
      logic [3:0] d;
      logic [4:0] e;
   } vec_t;

   vec_t vecs[$];

   // Expected {din_ready, busy, serial_in, shift, done}
   localparam logic [4:0] IDL = 5'b10000;
   localparam logic [4:0] DN  = 5'b10001;
   localparam logic [4:0] B00 = 5'b01000;
   localparam logic [4:0] B01 = 5'b01010;
   localparam logic [4:0] B10 = 5'b01100;
   localparam logic [4:0] B11 = 5'b01110;

   task automatic add(input logic r, input logic v, input logic l,
                      input logic [3:0] d, input logic [4:0] e);
      vec_t t;
      t.r = r; t.v = v; t.l = l; t.d = d; t.e = e;
      vecs.push_back(t);
   endtask

   task automatic applyStimulus(input vec_t t);
      rstN = t.r;
      vld  = t.v;
      lsb  = t.l;
      din  = t.d;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int doneCycle;
      int shiftBase;
      logic [10:1] shMask, dnMask, serMask;

      rstN = 1'b0; vld = 1'b0; lsb = 1'b0; din = 4'h0;

      // reset, then 1011 MSB first
      add(0,0,0,4'b0000,IDL); add(1,0,0,4'b0000,IDL);
      add(1,1,0,4'b1011,B10); add(1,0,0,4'b1011,B11);
      add(1,0,0,4'b0000,B00); add(1,0,0,4'b0000,B01);
      add(1,0,0,4'b0000,B10); add(1,0,0,4'b0000,B11);
      add(1,0,0,4'b0000,B10); add(1,0,0,4'b0000,B11);
      add(1,0,0,4'b0000,DN);  add(1,0,0,4'b0000,IDL);
      // 1011 LSB first with din/lsb/valid disturbed mid-word
      add(1,1,1,4'b1011,B10); add(1,0,0,4'b0000,B11);
      add(1,0,0,4'b0000,B10); add(1,0,0,4'b0000,B11);
      add(1,0,0,4'b0000,B00); add(1,0,0,4'b0000,B01);
      add(1,1,0,4'b1111,B10); add(1,1,0,4'b1111,B11);
      add(1,1,0,4'b0110,DN);
      // 0110 accepted on the done edge, aborted by reset after 2nd shift
      add(1,1,0,4'b0110,B00); add(1,0,0,4'b0000,B01);
      add(1,0,0,4'b0000,B10); add(1,0,0,4'b0000,B11);
      add(0,0,0,4'b0000,IDL); add(1,0,0,4'b0000,IDL);
      add(1,0,0,4'b0000,IDL);
      // reset wins over valid, then 0001 serializes cleanly
      add(0,1,0,4'b1111,IDL); add(1,0,0,4'b0000,IDL);
      add(1,1,0,4'b0001,B00); add(1,0,0,4'b0000,B01);
      add(1,0,0,4'b0000,B00); add(1,0,0,4'b0000,B01);
      add(1,0,0,4'b0000,B00); add(1,0,0,4'b0000,B01);
      add(1,0,0,4'b0000,B10); add(1,0,0,4'b0000,B11);
      add(1,0,0,4'b0000,DN);  add(1,0,0,4'b0000,IDL);

      #1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(posedge clk); #1;
         checkOutput($sformatf("vec%0d", i), {27'd0, rdy, bsy, ser, sh, dn},
                     {27'd0, vecs[i].e});
      end

      // Downstream capture and done timing for 1011 MSB first
      rstN = 1'b0; vld = 1'b0;
      @(posedge clk); #1;
      rstN = 1'b1; vld = 1'b1; din = 4'b1011; lsb = 1'b0;
      shiftBase = shiftCnt;
      @(posedge clk); #1;
      vld = 1'b0; din = 4'b0000;
      doneCycle = 0;
      for (int i = 1; i <= 20; i++) begin
         if (dn) begin
            doneCycle = i;
            break;
         end
         @(posedge clk); #1;
      end
      checkOutput("doneCycle", doneCycle, 9);
      checkOutput("sisoWord", {28'd0, siso}, 32'h0000000B);
      checkOutput("shiftCount", shiftCnt - shiftBase, 4);

      // DIV=1 back-to-back: A then 5 with valid held high
      rstN = 1'b0; vld = 1'b0;
      @(posedge clk); #1;
      rstN = 1'b1; vld = 1'b1; din = 4'hA; lsb = 1'b0;
      @(posedge clk); #1;
      din = 4'h5;
      shMask = '0; dnMask = '0; serMask = '0;
      for (int i = 1; i <= 10; i++) begin
         shMask[i]  = sh1;
         dnMask[i]  = dn1;
         serMask[i] = ser1;
         if (i == 6) vld = 1'b0;
         @(posedge clk); #1;
      end
      // cycle 1 is the LSB of each mask
      checkOutput("div1Shift",  {22'd0, shMask},  {22'd0, 10'b0111101111});
      checkOutput("div1Done",   {22'd0, dnMask},  {22'd0, 10'b1000010000});
      checkOutput("div1Serial", {22'd0, serMask}, {22'd0, 10'b0101000101});
      checkOutput("div1Idle", {30'd0, rdy1, bsy1}, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
